data_mem_ctrl: RTL and testbench
================================

Name: data_mem_ctrl

Overview:
- Parametrised data memory for the multi-cycle CPU.
- Supports byte, halfword and word (and doubleword when WIDTH=64) loads and stores, with sign or zero extension.
- Uses a valid/ready request and valid response handshake, registered read data, and alignment and range error reporting.
- After reset, a hardware clear sequencer zeroes the whole array before the first access is accepted.

Parameters:
- WIDTH, 32, data word width in bits; legal values are 32 or 64.
- DEPTH, 512, number of WIDTH-bit words; must be a power of two and at least 2.
- ADDR_W, 32, byte-address width.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request this cycle.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  access size: 0 = byte, 1 = half, 2 = word(32), 3 = dword(64).
- req_unsigned  in  1  loads only: 1 = zero-extend, 0 = sign-extend.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  WIDTH  store data; the active bytes are taken from the low bits.
- rsp_valid  out  1  one-cycle pulse; a response for the request accepted in the previous cycle.
- rsp_rdata  out  WIDTH  load result, extended to WIDTH; 0 for stores and errors.
- rsp_err  out  1  request was misaligned, out of range, or used an illegal size.
- init_busy  out  1  clear sequencer is running.

Behaviour:
- Definitions:
  - LB = log2(WIDTH/8).
  - Word index = req_addr >> LB.
  - Lane offset = req_addr[LB-1:0].
  - A request is accepted when req_valid && req_ready.
- Reset (rst=1 on a clock edge):
  - FSM enters INIT and clear counter = 0.
  - rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, req_ready = 0, init_busy = 1.
  - Applies in any state. A pending response is dropped, and any store accepted in the same cycle as rst is discarded.
- INIT:
  - Writes 0 to word[counter] and increments the counter, one word per cycle.
  - The write of word DEPTH-1 moves the FSM to RUN; init_busy falls and req_ready rises on that same edge.
  - The clear therefore takes exactly DEPTH cycles after rst deasserts.
  - req_ready = 0 throughout; req_valid is ignored.
- RUN:
  - req_ready = 1 every cycle, giving a throughput of 1 request per cycle.
  - Response latency is exactly 1 cycle: a request accepted at edge N produces rsp_valid=1 during cycle N+1.
  - Without an acceptance, rsp_valid = 0 in the following cycle.
  - No backpressure on responses.
- Legality: a request is legal only when all of the following hold; otherwise rsp_err = 1.
  - The size is supported: size 3 requires WIDTH = 64.
  - The address is aligned: half needs addr[0] = 0, word needs addr[1:0] = 0, dword needs addr[2:0] = 0.
  - The word index is < DEPTH, checked using the full ADDR_W address.
- Illegal requests: no write occurs, rsp_rdata = 0, and the response is still delivered after 1 cycle.
- Store:
  - Byte lanes [offset .. offset+bytes-1] of the word are written at the accept edge with req_wdata's low bytes.
  - All other lanes are unchanged.
  - Response: rsp_rdata = 0, rsp_err = 0.
- Load:
  - The word is read at the accept edge and the selected lanes are shifted to bit 0.
  - The result is extended to WIDTH: zero-extended if req_unsigned, otherwise extended from the access's MSB.
  - A full-width load ignores req_unsigned.
- Ordering: a store accepted at edge N is visible to a load accepted at edge N+1 (read-after-write, no stale data).
- Outputs are registered; there is no combinational path from req_* to rsp_*.

Test Plan:
- Reset, then hold rst=0 with WIDTH=32, DEPTH=512 -> init_busy=1 and req_ready=0 for exactly 512 cycles, then req_ready=1; a word load at 0x7FC returns 0x00000000.
- Word store 0x8000FF7F at 0x10, then byte loads at 0x10 and 0x11 (signed), then a half load at 0x12 (unsigned), issued back-to-back -> rdata 0x0000007F, 0xFFFFFFFF, 0x00008000; each rsp_valid appears one cycle after its accept.
- Byte store 0xAB at 0x21 over the word 0x11223344 at 0x20 -> word load at 0x20 returns 0x1122AB44 (other lanes preserved).
- Half load at 0x03, word store at 0x06, and word load at 0x800 (index 512) -> rsp_err=1 and rdata=0 for each; the word at 0x04 is unchanged.
- With WIDTH=32, a size=3 request -> rsp_err=1; with WIDTH=64, a dword store then load of 0x0123456789ABCDEF at 0x08 round-trips exactly.
- Assert rst for 1 cycle while a load response is pending and after nonzero data was written -> rsp_valid=0 the next cycle, init_busy=1 for DEPTH cycles, and the previously written word then reads 0.

Source files
------------

// File: rtl/data_mem_ctrl.sv
// Byte-addressable data memory with sized/extended loads and byte-lane stores; a clear sequencer zeroes it after reset.
// Latency: 1 cycle request-to-response. Backpressure: req_ready low only while clearing; responses cannot be stalled.
module data_mem_ctrl #(
    parameter int WIDTH  = 32,
    parameter int DEPTH  = 512,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [WIDTH-1:0]  req_wdata,
    output logic              rsp_valid,
    output logic [WIDTH-1:0]  rsp_rdata,
    output logic              rsp_err,
    output logic              init_busy
);

    localparam int NB    = WIDTH / 8;
    localparam int LB    = $clog2(NB);
    localparam int IDX_W = $clog2(DEPTH);

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   cnt_q, cnt_d;
    logic               ready_q, ready_d;
    logic               busy_q, busy_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic               rsp_err_q, rsp_err_d;
    logic [WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;

    logic [WIDTH-1:0]   mem_q [DEPTH];

    logic [LB-1:0]      lane_off;
    logic [IDX_W-1:0]   word_idx;
    logic               in_range;
    logic               aligned;
    logic               size_ok;
    logic               legal;
    logic               accept;

    logic [WIDTH-1:0]   rd_shift;
    logic               load_msb;
    int                 load_bits;
    logic [WIDTH-1:0]   load_ext;

    logic               mem_we;
    logic [IDX_W-1:0]   mem_widx;
    logic [NB-1:0]      mem_bmask;
    logic [WIDTH-1:0]   mem_wdata;
    int                 n_bytes;

    assign lane_off = req_addr[LB-1:0];
    assign word_idx = req_addr[LB +: IDX_W];
    // Range is judged on the full address so aliasing upper bits are rejected.
    assign in_range = (req_addr >> (LB + IDX_W)) == '0;
    assign size_ok  = (req_size != 2'd3) || (WIDTH == 64);
    assign legal    = size_ok && aligned && in_range;
    assign accept   = req_valid && ready_q;

    always_comb begin
        aligned = 1'b1;
        case (req_size)
            2'd0:    aligned = 1'b1;
            2'd1:    aligned = (req_addr[0] == 1'b0);
            2'd2:    aligned = (req_addr[1:0] == 2'b00);
            default: aligned = (req_addr[2:0] == 3'b000);
        endcase
    end

    // Load path: pick the addressed lanes, then sign- or zero-extend.
    assign rd_shift = mem_q[word_idx] >> {lane_off, 3'b000};

    always_comb begin
        load_msb  = rd_shift[WIDTH-1];
        load_bits = 8 << req_size;
        if (load_bits > WIDTH) begin
            load_bits = WIDTH;
        end
        case (req_size)
            2'd0:    load_msb = rd_shift[7];
            2'd1:    load_msb = rd_shift[15];
            2'd2:    load_msb = rd_shift[31];
            default: load_msb = rd_shift[WIDTH-1];
        endcase
        load_ext = '0;
        for (int b = 0; b < WIDTH; b++) begin
            load_ext[b] = (b < load_bits) ? rd_shift[b] : (!req_unsigned && load_msb);
        end
    end

    // Write port is shared by the clear sequencer and stores.
    always_comb begin
        mem_we    = 1'b0;
        mem_widx  = word_idx;
        mem_wdata = req_wdata << {lane_off, 3'b000};
        mem_bmask = '0;
        n_bytes   = 1 << req_size;
        for (int i = 0; i < NB; i++) begin
            mem_bmask[i] = (i >= int'(lane_off)) && (i < int'(lane_off) + n_bytes);
        end
        if (!rst) begin
            if (state_q == ST_INIT) begin
                mem_we    = 1'b1;
                mem_widx  = cnt_q;
                mem_bmask = '1;
                mem_wdata = '0;
            end else if (accept && req_we && legal) begin
                mem_we = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < NB; i++) begin
                if (mem_bmask[i]) begin
                    mem_q[mem_widx][i*8 +: 8] <= mem_wdata[i*8 +: 8];
                end
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        ready_d     = ready_q;
        busy_d      = busy_q;
        rsp_valid_d = accept;
        rsp_err_d   = accept && !legal;
        rsp_rdata_d = (accept && legal && !req_we) ? load_ext : '0;
        if (state_q == ST_INIT) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == IDX_W'(DEPTH - 1)) begin
                state_d = ST_RUN;
                ready_d = 1'b1;
                busy_d  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_INIT;
            cnt_q       <= '0;
            ready_q     <= 1'b0;
            busy_q      <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ready_q     <= ready_d;
            busy_q      <= busy_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign req_ready = ready_q;
    assign init_busy = busy_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Bench for data_mem_ctrl: a 32-bit/512-word instance and a 64-bit/16-word instance, scoreboard-checked.
module tb_data_mem_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [63:0] rdata;
        logic        err;
        int          cyc;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    exp_t ea, eb;

    logic        a_rst, a_req_valid, a_req_ready, a_req_we, a_req_unsigned;
    logic [1:0]  a_req_size;
    logic [31:0] a_req_addr, a_req_wdata, a_rsp_rdata;
    logic        a_rsp_valid, a_rsp_err, a_init_busy;

    logic        b_rst, b_req_valid, b_req_ready, b_req_we, b_req_unsigned;
    logic [1:0]  b_req_size;
    logic [31:0] b_req_addr;
    logic [63:0] b_req_wdata, b_rsp_rdata;
    logic        b_rsp_valid, b_rsp_err, b_init_busy;

    data_mem_ctrl #(.WIDTH(32), .DEPTH(512), .ADDR_W(32)) u_a (
        .clk(clk), .rst(a_rst),
        .req_valid(a_req_valid), .req_ready(a_req_ready), .req_we(a_req_we),
        .req_size(a_req_size), .req_unsigned(a_req_unsigned), .req_addr(a_req_addr),
        .req_wdata(a_req_wdata), .rsp_valid(a_rsp_valid), .rsp_rdata(a_rsp_rdata),
        .rsp_err(a_rsp_err), .init_busy(a_init_busy)
    );

    data_mem_ctrl #(.WIDTH(64), .DEPTH(16), .ADDR_W(32)) u_b (
        .clk(clk), .rst(b_rst),
        .req_valid(b_req_valid), .req_ready(b_req_ready), .req_we(b_req_we),
        .req_size(b_req_size), .req_unsigned(b_req_unsigned), .req_addr(b_req_addr),
        .req_wdata(b_req_wdata), .rsp_valid(b_rsp_valid), .rsp_rdata(b_rsp_rdata),
        .rsp_err(b_rsp_err), .init_busy(b_init_busy)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitors: pop one expectation per response and check data, error and latency.
    always @(negedge clk) begin
        if (a_rsp_valid === 1'b1) begin
            if (qa.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL a_unexpected_rsp: got rsp_valid=1, expected no response (t=%0t)", $time);
            end else begin
                ea = qa.pop_front();
                chk("a_rdata", {32'b0, a_rsp_rdata}, ea.rdata);
                chk("a_err", {63'b0, a_rsp_err}, {63'b0, ea.err});
                chk("a_latency_cycle", 64'(cyc), 64'(ea.cyc));
            end
        end
    end

    always @(negedge clk) begin
        if (b_rsp_valid === 1'b1) begin
            if (qb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL b_unexpected_rsp: got rsp_valid=1, expected no response (t=%0t)", $time);
            end else begin
                eb = qb.pop_front();
                chk("b_rdata", b_rsp_rdata, eb.rdata);
                chk("b_err", {63'b0, b_rsp_err}, {63'b0, eb.err});
                chk("b_latency_cycle", 64'(cyc), 64'(eb.cyc));
            end
        end
    end

    task automatic issue_a(input logic we, input logic [1:0] size, input logic uns,
                           input logic [31:0] addr, input logic [31:0] wd,
                           input logic [63:0] exp_d, input logic exp_e);
        @(negedge clk);
        chk("a_req_ready", {63'b0, a_req_ready}, 64'd1);
        a_req_valid    = 1'b1;
        a_req_we       = we;
        a_req_size     = size;
        a_req_unsigned = uns;
        a_req_addr     = addr;
        a_req_wdata    = wd;
        qa.push_back('{rdata: exp_d, err: exp_e, cyc: cyc + 1});
    endtask

    task automatic issue_b(input logic we, input logic [1:0] size, input logic uns,
                           input logic [31:0] addr, input logic [63:0] wd,
                           input logic [63:0] exp_d, input logic exp_e);
        @(negedge clk);
        chk("b_req_ready", {63'b0, b_req_ready}, 64'd1);
        b_req_valid    = 1'b1;
        b_req_we       = we;
        b_req_size     = size;
        b_req_unsigned = uns;
        b_req_addr     = addr;
        b_req_wdata    = wd;
        qb.push_back('{rdata: exp_d, err: exp_e, cyc: cyc + 1});
    endtask

    task automatic idle_a();
        @(negedge clk);
        a_req_valid = 1'b0;
    endtask

    task automatic idle_b();
        @(negedge clk);
        b_req_valid = 1'b0;
    endtask

    // Counts cycles with init_busy high, starting from the current (post-reset) cycle.
    task automatic wait_init_a();
        int  n;
        logic rdy_seen;
        n = 0;
        rdy_seen = 1'b0;
        while (a_init_busy === 1'b1 && n < 600) begin
            if (a_req_ready !== 1'b0) rdy_seen = 1'b1;
            n++;
            @(negedge clk);
        end
        chk("a_init_cycles", 64'(n), 64'd512);
        chk("a_ready_during_init", {63'b0, rdy_seen}, 64'd0);
        chk("a_ready_after_init", {63'b0, a_req_ready}, 64'd1);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        a_rst = 1'b1; a_req_valid = 1'b0; a_req_we = 1'b0; a_req_size = 2'd0;
        a_req_unsigned = 1'b0; a_req_addr = '0; a_req_wdata = '0;
        b_rst = 1'b1; b_req_valid = 1'b0; b_req_we = 1'b0; b_req_size = 2'd0;
        b_req_unsigned = 1'b0; b_req_addr = '0; b_req_wdata = '0;

        repeat (3) @(negedge clk);
        chk("a_reset_rsp_valid", {63'b0, a_rsp_valid}, 64'd0);
        chk("a_reset_rsp_err", {63'b0, a_rsp_err}, 64'd0);
        chk("a_reset_rsp_rdata", {32'b0, a_rsp_rdata}, 64'd0);
        chk("a_reset_req_ready", {63'b0, a_req_ready}, 64'd0);
        chk("a_reset_init_busy", {63'b0, a_init_busy}, 64'd1);
        chk("b_reset_init_busy", {63'b0, b_init_busy}, 64'd1);
        a_rst = 1'b0;
        b_rst = 1'b0;
        wait_init_a();

        // Cleared memory, last word.
        issue_a(1'b0, 2'd2, 1'b0, 32'h7FC, 32'h0, 64'h0, 1'b0);

        // Word store then back-to-back sub-word loads.
        issue_a(1'b1, 2'd2, 1'b0, 32'h10, 32'h8000FF7F, 64'h0, 1'b0);
        issue_a(1'b0, 2'd0, 1'b0, 32'h10, 32'h0, 64'h0000007F, 1'b0);
        issue_a(1'b0, 2'd0, 1'b0, 32'h11, 32'h0, 64'hFFFFFFFF, 1'b0);
        issue_a(1'b0, 2'd1, 1'b1, 32'h12, 32'h0, 64'h00008000, 1'b0);
        issue_a(1'b0, 2'd1, 1'b0, 32'h12, 32'h0, 64'hFFFF8000, 1'b0);

        // Byte store preserves neighbouring lanes.
        issue_a(1'b1, 2'd2, 1'b0, 32'h20, 32'h11223344, 64'h0, 1'b0);
        issue_a(1'b1, 2'd0, 1'b0, 32'h21, 32'hFFFFFFAB, 64'h0, 1'b0);
        issue_a(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 64'h1122AB44, 1'b0);

        // Illegal requests: misaligned, out of range, unsupported size.
        issue_a(1'b1, 2'd2, 1'b0, 32'h04, 32'hCAFEF00D, 64'h0, 1'b0);
        issue_a(1'b0, 2'd1, 1'b0, 32'h03, 32'h0, 64'h0, 1'b1);
        issue_a(1'b1, 2'd2, 1'b0, 32'h06, 32'hDEADBEEF, 64'h0, 1'b1);
        issue_a(1'b0, 2'd2, 1'b0, 32'h800, 32'h0, 64'h0, 1'b1);
        issue_a(1'b1, 2'd2, 1'b0, 32'h1000_0004, 32'h12345678, 64'h0, 1'b1);
        issue_a(1'b0, 2'd3, 1'b0, 32'h08, 32'h0, 64'h0, 1'b1);
        issue_a(1'b0, 2'd2, 1'b0, 32'h04, 32'h0, 64'hCAFEF00D, 1'b0);
        idle_a();

        // Reset with a load in flight: response dropped, memory re-cleared.
        @(negedge clk);
        a_rst = 1'b1;
        a_req_valid = 1'b1; a_req_we = 1'b0; a_req_size = 2'd2; a_req_addr = 32'h10;
        @(negedge clk);
        a_rst = 1'b0;
        a_req_valid = 1'b0;
        chk("a_rst_drops_rsp", {63'b0, a_rsp_valid}, 64'd0);
        chk("a_rst_init_busy", {63'b0, a_init_busy}, 64'd1);
        wait_init_a();
        issue_a(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 64'h0, 1'b0);
        issue_a(1'b0, 2'd2, 1'b0, 32'h04, 32'h0, 64'h0, 1'b0);
        idle_a();

        // 64-bit instance: dword round trip and sub-word extraction.
        issue_b(1'b1, 2'd3, 1'b0, 32'h08, 64'h0123456789ABCDEF, 64'h0, 1'b0);
        issue_b(1'b0, 2'd3, 1'b0, 32'h08, 64'h0, 64'h0123456789ABCDEF, 1'b0);
        issue_b(1'b0, 2'd2, 1'b1, 32'h0C, 64'h0, 64'h0000000001234567, 1'b0);
        issue_b(1'b0, 2'd2, 1'b0, 32'h08, 64'h0, 64'hFFFFFFFF89ABCDEF, 1'b0);
        issue_b(1'b0, 2'd0, 1'b0, 32'h08, 64'h0, 64'hFFFFFFFFFFFFFFEF, 1'b0);
        issue_b(1'b0, 2'd3, 1'b0, 32'h04, 64'h0, 64'h0, 1'b1);
        issue_b(1'b0, 2'd3, 1'b0, 32'h80, 64'h0, 64'h0, 1'b1);
        issue_b(1'b0, 2'd3, 1'b0, 32'h00, 64'h0, 64'h0, 1'b0);
        idle_b();

        repeat (3) @(negedge clk);
        chk("a_pending_responses", 64'(qa.size()), 64'd0);
        chk("b_pending_responses", 64'(qb.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
